// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE bits retired per cycle, result returned with its destination tag.
module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned ITER  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state, nextState;

    logic [CNT_W-1:0] iterCnt;
    logic             lastIter;
    logic             accept;

    // Latched operation context
    logic [2:0]      func3Q;
    logic [4:0]      rdQ;
    logic            negQ;
    logic            negR;
    logic [XLEN-1:0] accHi;
    logic [XLEN-1:0] accLo;
    logic [XLEN-1:0] opnd;

    // Issue-time decode
    logic            isDivIn;
    logic            aSignedIn;
    logic            bSignedIn;
    logic            negAIn;
    logic            negBIn;
    logic [XLEN-1:0] magAIn;
    logic [XLEN-1:0] magBIn;
    logic            divByZero;
    logic            divOverflow;
    logic            specialCase;
    logic [XLEN-1:0] specialResult;

    // Iteration datapath
    logic [XLEN-1:0]     accHiN;
    logic [XLEN-1:0]     accLoN;
    logic [XLEN+BPC-1:0] mulSum;
    logic [XLEN:0]       remSh;
    logic [2*XLEN-1:0]   prodMag;
    logic [2*XLEN-1:0]   prodOut;
    logic [XLEN-1:0]     quoOut;
    logic [XLEN-1:0]     remOut;
    logic [XLEN-1:0]     calcResult;

    assign accept   = (state == IDLE) & start_i & ~flush_i;
    assign lastIter = (iterCnt == CNT_W'(ITER - 1));
    assign done_o   = (state == DONE) & ~flush_i;

    assign isDivIn   = func3_i[2];
    assign aSignedIn = (func3_i == 3'b001) | (func3_i == 3'b010) |
                       (func3_i == 3'b100) | (func3_i == 3'b110);
    assign bSignedIn = (func3_i == 3'b001) | (func3_i == 3'b100) | (func3_i == 3'b110);
    assign negAIn    = aSignedIn & op_a_i[XLEN-1];
    assign negBIn    = bSignedIn & op_b_i[XLEN-1];
    assign magAIn    = negAIn ? (-op_a_i) : op_a_i;
    assign magBIn    = negBIn ? (-op_b_i) : op_b_i;

    assign divByZero   = isDivIn & (op_b_i == '0);
    assign divOverflow = isDivIn & ~func3_i[0] & (op_a_i == MOST_NEG) & (op_b_i == '1);
    assign specialCase = divByZero | divOverflow;

    // b==0 and overflow are exclusive since overflow needs b==-1
    always_comb begin
        specialResult = '0;
        if (divByZero) begin
            specialResult = func3_i[1] ? op_a_i : '1;
        end else if (divOverflow) begin
            specialResult = func3_i[1] ? '0 : op_a_i;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = specialCase ? DONE : CALC;
            CALC: if (lastIter) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush_i) nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= nextState;
            busy_o <= (nextState != IDLE);
        end
    end

    // Multiply: accHi is the running high partial, accLo shifts multiplier out and product in.
    // Divide: accHi is the partial remainder, accLo shifts dividend out and quotient in.
    always_comb begin
        accHiN = accHi;
        accLoN = accLo;
        mulSum = '0;
        remSh  = '0;
        if (func3Q[2]) begin
            for (int i = 0; i < int'(BPC); i++) begin
                remSh  = {accHiN, accLoN[XLEN-1]};
                accLoN = {accLoN[XLEN-2:0], 1'b0};
                if (remSh >= {1'b0, opnd}) begin
                    remSh     = remSh - {1'b0, opnd};
                    accLoN[0] = 1'b1;
                end
                accHiN = remSh[XLEN-1:0];
            end
        end else begin
            mulSum = {BPC'(0), accHi}
                   + ((XLEN+BPC)'(opnd) * (XLEN+BPC)'(accLo[BPC-1:0]));
            accHiN = mulSum[XLEN+BPC-1:BPC];
            accLoN = {mulSum[BPC-1:0], accLo[XLEN-1:BPC]};
        end
    end

    always_comb begin
        prodMag    = {accHiN, accLoN};
        prodOut    = negQ ? (-prodMag) : prodMag;
        quoOut     = negQ ? (-accLoN) : accLoN;
        remOut     = negR ? (-accHiN) : accHiN;
        calcResult = '0;
        if (func3Q[2]) begin
            calcResult = func3Q[1] ? remOut : quoOut;
        end else begin
            calcResult = (func3Q[1:0] == 2'b00) ? prodOut[XLEN-1:0] : prodOut[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            func3Q   <= '0;
            rdQ      <= '0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            accHi    <= '0;
            accLo    <= '0;
            opnd     <= '0;
            iterCnt  <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            if (accept) begin
                func3Q  <= func3_i;
                rdQ     <= rd_i;
                negQ    <= negAIn ^ negBIn;
                negR    <= negAIn;
                iterCnt <= '0;
                accHi   <= '0;
                accLo   <= isDivIn ? magAIn : magBIn;
                opnd    <= isDivIn ? magBIn : magAIn;
            end else if (state == CALC) begin
                accHi   <= accHiN;
                accLo   <= accLoN;
                iterCnt <= iterCnt + CNT_W'(1);
            end
            if (nextState == DONE) begin
                result_o <= (state == IDLE) ? specialResult : calcResult;
                rd_o     <= (state == IDLE) ? rd_i : rdQ;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three instances (32/1, 32/4, 64/1) sharing stimulus,
// hand-computed results and done-cycle latencies.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  func3;
    logic [63:0] opA;
    logic [63:0] opB;
    logic [4:0]  rdIn;
    int          sel;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic [4:0]  rd0, rd1, rd2;

    logic        busyT, doneT;
    logic [63:0] resT;
    logic [4:0]  rdT;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start & (sel == 0)), .func3_i(func3),
        .op_a_i(opA[31:0]), .op_b_i(opB[31:0]), .rd_i(rdIn), .flush_i(flush),
        .busy_o(busy0), .done_o(done0), .result_o(res0), .rd_o(rd0));

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start & (sel == 1)), .func3_i(func3),
        .op_a_i(opA[31:0]), .op_b_i(opB[31:0]), .rd_i(rdIn), .flush_i(flush),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .rd_o(rd1));

    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start & (sel == 2)), .func3_i(func3),
        .op_a_i(opA), .op_b_i(opB), .rd_i(rdIn), .flush_i(flush),
        .busy_o(busy2), .done_o(done2), .result_o(res2), .rd_o(rd2));

    always_comb begin
        case (sel)
            1:       begin busyT = busy1; doneT = done1; resT = {32'b0, res1}; rdT = rd1; end
            2:       begin busyT = busy2; doneT = done2; resT = res2;          rdT = rd2; end
            default: begin busyT = busy0; doneT = done0; resT = {32'b0, res0}; rdT = rd0; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: issues in that cycle (cycle 0), waits for done, checks the
    // done cycle, busy coverage, result, tag, and the idle cycle that follows.
    task automatic runOp(input string tag, input int s, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] expRes, input int expCyc);
        int          doneCyc = -1;
        int          busyBad = 0;
        logic [63:0] gotRes  = '0;
        logic [4:0]  gotRd   = '0;
        sel = s; func3 = f; opA = a; opB = b; rdIn = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; func3 = ~f; opA = ~a; opB = ~b; rdIn = ~rd;
        for (int cyc = 1; cyc <= expCyc + 4 && doneCyc < 0; cyc++) begin
            if (!busyT) busyBad++;
            if (doneT) begin
                doneCyc = cyc;
                gotRes  = resT;
                gotRd   = rdT;
            end
            @(negedge clk);
        end
        checkVal({tag, "_done_cycle"}, 64'(doneCyc), 64'(expCyc));
        checkVal({tag, "_result"}, gotRes, expRes);
        checkVal({tag, "_rd"}, 64'(gotRd), 64'(rd));
        checkVal({tag, "_busy_gaps"}, 64'(busyBad), 64'(0));
        checkVal({tag, "_idle_after"}, {62'b0, busyT, doneT}, 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0;
        opA = '0; opB = '0; rdIn = '0; sel = 0;
        repeat (3) @(negedge clk);
        checkVal("reset_busy", 64'(busyT), 64'(0));
        checkVal("reset_done", 64'(doneT), 64'(0));
        checkVal("reset_result", resT, 64'(0));
        checkVal("reset_rd", 64'(rdT), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        runOp("mul",     0, 3'b000, 64'h7,        64'hFFFFFFFD, 5'd3,  64'hFFFFFFEB, 33);
        runOp("mulh",    0, 3'b001, 64'h80000000, 64'h80000000, 5'd4,  64'h40000000, 33);
        runOp("mulhu",   0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5,  64'hFFFFFFFE, 33);
        runOp("mulhsu",  0, 3'b010, 64'hFFFFFFFF, 64'h2,        5'd6,  64'hFFFFFFFF, 33);
        runOp("div",     0, 3'b100, 64'hFFFFFFF9, 64'h2,        5'd7,  64'hFFFFFFFD, 33);
        runOp("rem",     0, 3'b110, 64'hFFFFFFF9, 64'h2,        5'd8,  64'hFFFFFFFF, 33);
        runOp("divu",    0, 3'b101, 64'd100,      64'd7,        5'd9,  64'd14,       33);
        runOp("remu",    0, 3'b111, 64'd100,      64'd7,        5'd10, 64'd2,        33);
        runOp("rem_negb",0, 3'b110, 64'd7,        64'hFFFFFFFE, 5'd11, 64'd1,        33);
        runOp("div_z",   0, 3'b100, 64'd5,        64'd0,        5'd12, 64'hFFFFFFFF, 1);
        runOp("rem_z",   0, 3'b110, 64'd5,        64'd0,        5'd13, 64'd5,        1);
        runOp("remu_z",  0, 3'b111, 64'd9,        64'd0,        5'd14, 64'd9,        1);
        runOp("div_ovf", 0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd15, 64'h80000000, 1);
        runOp("rem_ovf", 0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd16, 64'h0,        1);

        // Flush a DIV in cycle 10, then issue again in cycle 11
        sel = 0; func3 = 3'b100; opA = 64'hFFFFFFF9; opB = 64'h2; rdIn = 5'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 10; c++) begin
            if (doneT) nd++;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
        end
        flush = 1'b0;
        checkVal("flush_busy", 64'(busyT), 64'(0));
        checkVal("flush_no_done", 64'(nd + int'(doneT)), 64'(0));
        runOp("after_flush", 0, 3'b101, 64'd100, 64'd7, 5'd18, 64'd14, 33);

        // start coincident with flush is dropped
        sel = 0; func3 = 3'b000; opA = 64'd3; opB = 64'd5; rdIn = 5'd19;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        nd = 0;
        checkVal("start_flush_busy", 64'(busyT), 64'(0));
        for (int c = 0; c < 4; c++) begin
            if (doneT || busyT) nd++;
            @(negedge clk);
        end
        checkVal("start_flush_quiet", 64'(nd), 64'(0));

        // Reset in cycle 5 of a MUL clears everything
        sel = 0; func3 = 3'b000; opA = 64'd3; opB = 64'd5; rdIn = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkVal("midreset_busy", 64'(busyT), 64'(0));
        checkVal("midreset_done", 64'(doneT), 64'(0));
        checkVal("midreset_result", resT, 64'(0));
        checkVal("midreset_rd", 64'(rdT), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        runOp("r4_mul",  1, 3'b000, 64'h7,        64'hFFFFFFFD, 5'd21, 64'hFFFFFFEB, 9);
        runOp("r4_mulh", 1, 3'b001, 64'h80000000, 64'h80000000, 5'd22, 64'h40000000, 9);
        runOp("r4_div",  1, 3'b100, 64'hFFFFFFF9, 64'h2,        5'd23, 64'hFFFFFFFD, 9);
        runOp("r4_rem",  1, 3'b110, 64'hFFFFFFF9, 64'h2,        5'd24, 64'hFFFFFFFF, 9);

        runOp("x64_mul", 2, 3'b000, 64'hFFFFFFFFFFFFFFFF, 64'h2, 5'd25, 64'hFFFFFFFFFFFFFFFE, 65);
        runOp("x64_div", 2, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'h2, 5'd26, 64'hFFFFFFFFFFFFFFFD, 65);
        runOp("x64_remu",2, 3'b111, 64'd100,              64'd7, 5'd27, 64'd2,                65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide execution unit implementing all eight RV32M operations.
- Sits beside the EX-stage ALU. The hazard unit stalls F/D/E while busy_o is high.
- The result returns with its destination register tag for the M/W path.
- Operation width and radix (bits retired per cycle) are parameters, so one block serves RV32/RV64 and area/latency trade-offs.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, quotient/multiplier bits processed per iteration. Legal values are 1, 2, 4, and XLEN must be divisible by it.
- ITER (derived, not overridable), XLEN/BITS_PER_CYCLE, number of compute cycles.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start_i  input  1  issue request, single-cycle pulse from EX.
- func3_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  XLEN  rs1 operand (forwarded value).
- op_b_i  input  XLEN  rs2 operand (forwarded value).
- rd_i  input  5  destination register tag.
- flush_i  input  1  abort current operation (branch/jump flush of E).
- busy_o  output  1  operation in progress; stall request.
- done_o  output  1  one-cycle result-valid strobe.
- result_o  output  XLEN  result, registered.
- rd_o  output  5  tag of result_o.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, busy_o=0, done_o=0, result_o=0, rd_o=0, all iteration registers cleared. Reset takes effect from any state and aborts any operation in flight.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on start_i & ~flush_i.
  - IDLE -> DONE on start_i & ~flush_i when the operation is a special-case divide (see below).
  - CALC -> DONE after ITER cycles in CALC.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush_i.
- Handshake:
  - Operands, func3, and rd are latched only on an accepted start.
  - start_i is ignored when state != IDLE.
  - busy_o = (state != IDLE), registered.
  - done_o = (state == DONE) & ~flush_i.
  - result_o and rd_o update on entry to DONE and hold until the next entry to DONE.
- Latency: with start accepted at cycle 0, done_o is high in cycle ITER+1. For XLEN=32 and BITS_PER_CYCLE=1 that is cycle 33. Special-case divides complete with done_o high in cycle 1.
- Multiply:
  - Operands are converted to magnitudes per signedness: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU and MUL unsigned x unsigned (MUL low half is sign-agnostic).
  - A 2*XLEN product is accumulated by shift-add, BITS_PER_CYCLE multiplier bits per cycle.
  - In the final cycle the product is negated if the operand signs differ.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle.
  - Quotient sign = sign(a) ^ sign(b). Remainder sign = sign(a). Signs apply only for DIV/REM.
- Special cases, detected on acceptance:
  - b==0: DIV/DIVU return all-ones, REM/REMU return a.
  - Signed overflow (a = most-negative, b = -1): DIV returns a, REM returns 0.
- Flush:
  - flush_i in CALC: the operation is discarded, busy_o is low next cycle, and done_o never pulses.
  - flush_i coincident with start_i: start is ignored.
  - flush_i in the DONE cycle: done_o is suppressed that cycle, result_o/rd_o still update, and consumers ignore them.
- Back-to-back operation: a new start is accepted in the IDLE cycle immediately after DONE, giving a minimum issue interval of ITER+2 cycles.
- Signals are never X after reset. Arithmetic is exact modulo 2^XLEN.

Test Plan:
- XLEN=32, BPC=1. MUL a=7, b=0xFFFFFFFD -> done_o high only in cycle 33, result_o=0xFFFFFFEB, busy_o high in cycles 1-33, rd_o = issued tag.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same -> 2.
- DIV a=5, b=0 -> 0xFFFFFFFF with done_o in cycle 1. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same -> 0.
- flush_i in cycle 10 of a DIV -> busy_o=0 in cycle 11, no done_o. Start in cycle 11 is accepted and completes in cycle 44. rst_n=0 in cycle 5 of a MUL -> all outputs 0 next cycle.
- Re-run the first and third scenarios with BITS_PER_CYCLE=4 (done_o in cycle 9) and with XLEN=64 (MUL 0xFFFFFFFFFFFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE, done_o in cycle 65).
